fp_conv_sched: RTL and testbench

//  Shares one 12-bit two's-complement -> 8-bit float (s,e[2:0],f[3:0]) conversion datapath among NREQ requesters.

---
 rtl/fp_conv_sched.sv | 151 +++++++++++++++
 tb/tb_fp_conv_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_conv_sched.sv
// Round-robin shared converter: 12-bit two's complement -> 8-bit float (s, e[2:0], f[3:0]),
// sequenced IDLE -> MAG -> NORM -> HOLD, with an ID-tagged valid/ready result port.
module fp_conv_sched #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [12*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_s,
  output logic [2:0]         res_e,
  output logic [3:0]         res_f,
  output logic [ID_W-1:0]    res_id,
  output logic [7:0]         sat_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_MAG, S_NORM, S_HOLD} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] rr_ptr, gnt, cur_id;
  logic            found;
  logic [11:0]     sel_data, word, mag;
  logic            sgn, sat_flag;
  logic [3:0]      msb, n_e, n_f;
  logic            n_sat;
  logic [11:0]     shifted;
  logic [4:0]      f_sum;
  int unsigned     idx;

  // First valid requester searching upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        gnt   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt == ID_W'(i)) sel_data = req_data[12*i +: 12];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && found) req_ready[gnt] = 1'b1;
  end

  assign res_valid = (state == S_HOLD);

  // e = msb-3 equals 8-lz; values below 16 pass through unrounded with e=0.
  always_comb begin
    msb     = '0;
    n_e     = '0;
    n_f     = '0;
    n_sat   = 1'b0;
    shifted = '0;
    f_sum   = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (mag[i]) msb = 4'(i);
    end
    if (msb < 4'd4) begin
      n_f = mag[3:0];
    end else begin
      n_e     = msb - 4'd3;
      shifted = mag >> (n_e - 4'd1);
      f_sum   = {1'b0, shifted[4:1]} + {4'b0, shifted[0]};
      if (f_sum[4]) begin
        n_f = 4'd8;
        n_e = n_e + 4'd1;
      end else begin
        n_f = f_sum[3:0];
      end
      if (n_e == 4'd8) begin
        n_e   = 4'd7;
        n_f   = 4'd15;
        n_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (found) state_nx = S_MAG;
      S_MAG:  state_nx = S_NORM;
      S_NORM: state_nx = S_HOLD;
      S_HOLD: if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      cur_id   <= '0;
      word     <= '0;
      mag      <= '0;
      sgn      <= 1'b0;
      sat_flag <= 1'b0;
      res_s    <= 1'b0;
      res_e    <= '0;
      res_f    <= '0;
      res_id   <= '0;
      sat_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          word   <= sel_data;
          cur_id <= gnt;
          rr_ptr <= (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + ID_W'(1);
        end
        S_MAG: begin
          sgn <= word[11];
          if (word == 12'h800) begin
            mag      <= 12'd2047;
            sat_flag <= 1'b1;
          end else begin
            mag      <= word[11] ? -word : word;
            sat_flag <= 1'b0;
          end
        end
        S_NORM: begin
          res_s  <= sgn;
          res_e  <= n_e[2:0];
          res_f  <= n_f;
          res_id <= cur_id;
          if ((n_sat || sat_flag) && sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_conv_sched.sv
// Directed bench for fp_conv_sched (NREQ=2): conversion, rounding, saturation, arbitration,
// backpressure and mid-operation reset.
module tb_fp_conv_sched;
  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [12*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic              res_s;
  logic [2:0]        res_e;
  logic [3:0]        res_f;
  logic [ID_W-1:0]   res_id;
  logic [7:0]        sat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fp_conv_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_e(res_e), .res_f(res_f), .res_id(res_id), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ":res_valid"}, 32'(res_valid), 0);
    check({tag, ":req_ready"}, 32'(req_ready), 0);
    check({tag, ":sat_cnt"},   32'(sat_cnt), 0);
    check({tag, ":res_sef"},   {24'b0, res_s, res_e, res_f}, 0);
    check({tag, ":res_id"},    32'(res_id), 0);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":res_valid"}, 32'(res_valid), 1);
  endtask

  // One word from a lone requester; checks grant, 2-cycle latency and the result fields.
  task automatic do_word(input int id, input logic [11:0] d, input logic es,
                         input logic [2:0] ee, input logic [3:0] ef, input string tag);
    int t;
    int lat;
    @(negedge clk);
    req_data[12*id +: 12] = d;
    req_valid[id] = 1'b1;
    t = 0;
    #1;
    while (!req_ready[id] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, ":grant"}, 32'(req_ready), 32'(1 << id));
    if (t >= 20) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    wait_result(tag, lat);
    check({tag, ":latency"}, 32'(lat), 2);
    check({tag, ":s"},  32'(res_s), 32'(es));
    check({tag, ":e"},  32'(res_e), 32'(ee));
    check({tag, ":f"},  32'(res_f), 32'(ef));
    check({tag, ":id"}, 32'(res_id), 32'(id));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int ng;
    int nr;
    int grants[8];
    int ids[8];
    int fs[8];

    apply_reset();

    do_word(0, 12'd44,   1'b0, 3'd2, 4'd11, "single44");
    do_word(0, 12'd31,   1'b0, 3'd2, 4'd8,  "rnd31");
    do_word(0, 12'd46,   1'b0, 3'd2, 4'd12, "rnd46");
    do_word(0, 12'd45,   1'b0, 3'd2, 4'd11, "rnd45");
    do_word(0, 12'hFD4,  1'b1, 3'd2, 4'd11, "neg44");
    do_word(0, 12'd0,    1'b0, 3'd0, 4'd0,  "zero");
    do_word(0, 12'd13,   1'b0, 3'd0, 4'd13, "small13");
    check("sat_cnt_pre", 32'(sat_cnt), 0);
    do_word(0, 12'd2047, 1'b0, 3'd7, 4'd15, "sat2047");
    check("sat_cnt_1", 32'(sat_cnt), 1);
    do_word(0, 12'h800,  1'b1, 3'd7, 4'd15, "sat800");
    check("sat_cnt_2", 32'(sat_cnt), 2);

    // Backpressure: result held 10 cycles while req0 waits.
    @(negedge clk);
    res_ready = 1'b0;
    req_data[23:12] = 12'd46;
    req_valid = 2'b10;
    #1;
    check("bp:grant1", 32'(req_ready), 32'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b01;
    req_data[11:0] = 12'd31;
    wait_result("bp", lat);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp:hold_valid", 32'(res_valid), 1);
      check("bp:hold_ef",    {25'b0, res_e, res_f}, {25'b0, 3'd2, 4'd12});
      check("bp:hold_id",    32'(res_id), 1);
      check("bp:no_ready",   32'(req_ready), 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp:released", 32'(res_valid), 0);
    check("bp:grant0",   32'(req_ready), 32'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_result("bp2", lat);
    check("bp2:ef", {25'b0, res_e, res_f}, {25'b0, 3'd2, 4'd8});
    check("bp2:id", 32'(res_id), 0);

    // Reset while a saturating word sits in NORM.
    @(negedge clk);
    req_data[11:0] = 12'd2047;
    req_valid = 2'b01;
    #1;
    check("rst:grant", 32'(req_ready), 32'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    req_data = {12'd45, 12'd46};
    req_valid = 2'b11;
    #1;
    check("rst:next_grant", 32'(req_ready), 32'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_result("rst_after", lat);
    check("rst_after:ef",  {25'b0, res_e, res_f}, {25'b0, 3'd2, 4'd12});
    check("rst_after:id",  32'(res_id), 0);
    check("rst_after:sat", 32'(sat_cnt), 0);

    // Arbitration: both requesters valid continuously.
    @(negedge clk);
    apply_reset();
    req_data = {12'd46, 12'd44};
    req_valid = 2'b11;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      #1;
      if (req_ready != '0 && ng < 8) begin
        grants[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
      if (res_valid && nr < 8) begin
        ids[nr] = int'(res_id);
        fs[nr]  = int'(res_f);
        nr++;
      end
      if (nr < 4) @(negedge clk);
    end
    req_valid = '0;
    check("arb:results", 32'(nr), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arb:grant%0d", i), 32'(grants[i]), 32'(i % 2));
      check($sformatf("arb:id%0d", i),    32'(ids[i]),    32'(i % 2));
      check($sformatf("arb:f%0d", i),     32'(fs[i]),     (i % 2) ? 12 : 11);
    end

    // sat_cnt saturates at 255.
    for (int i = 0; i < 300; i++) begin
      do_word(0, 12'd2047, 1'b0, 3'd7, 4'd15, "satloop");
      if (i == 253) check("sat_cnt_254", 32'(sat_cnt), 254);
    end
    check("sat_cnt_255", 32'(sat_cnt), 255);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
